dft_host_link: RTL and testbench



---
 rtl/dft_host_pkg.sv | 24 ++
 rtl/dft_host_skid.sv | 85 ++++++++
 rtl/dft_host_link.sv | 205 ++++++++++++++++++++
 tb/tb_dft_host_link.sv | 415 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dft_host_pkg.sv
// ----------------------------------------------------------------------------
// dft_host_pkg
// Shared definitions for the DFT host link: default widths, watchdog limit,
// skid credit width and the controller state encoding.
// ----------------------------------------------------------------------------
package dft_host_pkg;

    localparam int unsigned ADDR_W_DEF      = 12;
    localparam int unsigned BURST_W_DEF     = 4;
    localparam int unsigned TIMEOUT_CYC_DEF = 4096;

    // Credit = buffered words + in-flight read; never exceeds 2.
    localparam int unsigned CREDIT_MAX = 2;
    localparam int unsigned CREDIT_W   = 2;

    typedef enum logic [2:0] {
        StIdle,
        StSend,
        StRecv,
        StDone,
        StAbort
    } host_state_e;

endpackage

// File: rtl/dft_host_skid.sv
// ----------------------------------------------------------------------------
// dft_host_skid
// Two-entry FIFO between the synchronous-read source memory and the
// accelerator read channel. A read issued in cycle t returns data on
// i_src_data in t+1; when the FIFO is empty that word is presented directly
// (bypass) so a sample can be offered the same cycle it arrives.
//
// Ports:
//   clk, n_Reset    clock, asynchronous active-low reset
//   i_flush         synchronous clear of FIFO and in-flight read
//   i_rd_issue      a source read is issued this cycle
//   i_src_data      source memory data (valid the cycle after a read)
//   i_ready         consumer accepts the head word
//   o_valid         head word available
//   o_data          head word
//   o_credit        buffered words + in-flight read
// ----------------------------------------------------------------------------
module dft_host_skid
    import dft_host_pkg::*;
#(
    parameter int unsigned DATA_W = 32
) (
    input  logic                clk,
    input  logic                n_Reset,
    input  logic                i_flush,
    input  logic                i_rd_issue,
    input  logic [DATA_W-1:0]   i_src_data,
    input  logic                i_ready,
    output logic                o_valid,
    output logic [DATA_W-1:0]   o_data,
    output logic [CREDIT_W-1:0] o_credit
);

    logic                r_pend;
    logic [DATA_W-1:0]   r_mem [2];
    logic                r_rd_ptr;
    logic                r_wr_ptr;
    logic [CREDIT_W-1:0] r_count;

    logic w_empty;
    logic w_pop;
    logic w_push;
    logic w_head_pop;

    assign w_empty    = (r_count == '0);
    assign o_valid    = !w_empty || r_pend;
    assign o_data     = w_empty ? i_src_data : r_mem[r_rd_ptr];
    assign w_pop      = o_valid && i_ready;
    // Arriving word is stored unless it bypasses an empty FIFO and is taken now.
    assign w_push     = r_pend && !(w_empty && w_pop);
    assign w_head_pop = w_pop && !w_empty;
    assign o_credit   = r_count + CREDIT_W'(r_pend);

    always_ff @(posedge clk or negedge n_Reset) begin
        if (!n_Reset) begin
            r_pend   <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_wr_ptr <= 1'b0;
            r_count  <= '0;
            for (int i = 0; i < 2; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_flush) begin
            r_pend   <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_wr_ptr <= 1'b0;
            r_count  <= '0;
        end else begin
            r_pend <= i_rd_issue;
            if (w_push) begin
                r_mem[r_wr_ptr] <= i_src_data;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (w_head_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({w_push, w_head_pop})
                2'b10:   r_count <= r_count + CREDIT_W'(1);
                2'b01:   r_count <= r_count - CREDIT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/dft_host_link.sv
// ----------------------------------------------------------------------------
// dft_host_link
// Host side of the DFT accelerator bridge. On a start pulse it streams n
// samples from source memory onto the accelerator read channel (RDATA/RVALID,
// honouring RREADY), then accepts n results on the write channel
// (WVALID/WREADY) and writes them to result memory.
//
// Optional feature: define DFT_HOST_TIMEOUT_EN to enable a watchdog that
// aborts a transfer after TIMEOUT_CYC cycles without a handshake.
//
// Ports:
//   clk, n_Reset                   clock, asynchronous active-low reset
//   i_start, i_samp_number         start pulse and block length
//   o_busy, o_done, o_error        status
//   o_src_addr, o_src_rd, i_src_data   source memory read port
//   o_dst_addr, o_dst_wr, o_dst_data   result memory write port
//   o_RDATA, o_RVALID, i_RREADY, i_RBURST   accelerator read channel
//   i_WDATA, i_WVALID, o_WREADY, i_WBURST   accelerator write channel
// ----------------------------------------------------------------------------
module dft_host_link
    import dft_host_pkg::*;
#(
    parameter int unsigned ADDR_W      = ADDR_W_DEF,
    parameter int unsigned BURST_W     = BURST_W_DEF,
    parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic               clk,
    input  logic               n_Reset,
    input  logic               i_start,
    input  logic [ADDR_W-1:0]  i_samp_number,
    output logic               o_busy,
    output logic               o_done,
    output logic               o_error,
    output logic [ADDR_W-1:0]  o_src_addr,
    output logic               o_src_rd,
    input  logic [31:0]        i_src_data,
    output logic [ADDR_W-1:0]  o_dst_addr,
    output logic               o_dst_wr,
    output logic [31:0]        o_dst_data,
    output logic [31:0]        o_RDATA,
    output logic               o_RVALID,
    input  logic               i_RREADY,
    input  logic [BURST_W-1:0] i_RBURST,
    input  logic [31:0]        i_WDATA,
    input  logic               i_WVALID,
    output logic               o_WREADY,
    input  logic [BURST_W-1:0] i_WBURST
);

    host_state_e r_state;
    host_state_e w_state_next;

    logic [ADDR_W-1:0] r_n;
    logic [ADDR_W-1:0] r_rd_idx;
    logic [ADDR_W-1:0] r_beat_idx;
    logic [ADDR_W-1:0] r_res_idx;

    logic [ADDR_W-1:0]   w_n_last;
    logic                w_start_ok;
    logic                w_skid_valid;
    logic                w_skid_ready;
    logic [31:0]         w_skid_data;
    logic [CREDIT_W-1:0] w_credit;
    logic                w_beat;
    logic                w_rd_issue;
    logic                w_flush;
    logic                w_timeout;
    logic                w_unused;

    // Burst tags are monitored only; the watchdog limit is idle without the feature.
    assign w_unused = ^{i_RBURST, i_WBURST, 32'(TIMEOUT_CYC)};

    assign w_n_last     = r_n - ADDR_W'(1);
    assign w_start_ok   = (r_state == StIdle) && i_start && (i_samp_number != '0);
    assign w_skid_ready = (r_state == StSend) && i_RREADY;
    assign w_beat       = w_skid_valid && w_skid_ready;
    assign w_flush      = w_start_ok || (r_state == StAbort);

    dft_host_skid #(
        .DATA_W (32)
    ) u_skid (
        .clk        (clk),
        .n_Reset    (n_Reset),
        .i_flush    (w_flush),
        .i_rd_issue (w_rd_issue),
        .i_src_data (i_src_data),
        .i_ready    (w_skid_ready),
        .o_valid    (w_skid_valid),
        .o_data     (w_skid_data),
        .o_credit   (w_credit)
    );

    assign o_RVALID   = w_skid_valid && (r_state == StSend);
    assign o_RDATA    = o_RVALID ? w_skid_data : '0;
    assign o_src_rd   = w_rd_issue;
    assign o_src_addr = r_rd_idx;
    assign o_dst_wr   = i_WVALID && o_WREADY;
    assign o_dst_addr = r_res_idx;
    assign o_dst_data = o_dst_wr ? i_WDATA : '0;

    always_comb begin
        w_state_next = r_state;
        o_busy       = 1'b0;
        o_done       = 1'b0;
        o_WREADY     = 1'b0;
        w_rd_issue   = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (w_start_ok) begin
                    w_state_next = StSend;
                end
            end
            StSend: begin
                o_busy = 1'b1;
                // A full credit frees up when a beat leaves this cycle.
                w_rd_issue = (r_rd_idx < r_n) &&
                             ((w_credit < CREDIT_W'(CREDIT_MAX)) ||
                              ((w_credit == CREDIT_W'(CREDIT_MAX)) && w_beat));
                if (w_beat && (r_beat_idx == w_n_last)) begin
                    w_state_next = StRecv;
                end else if (w_timeout) begin
                    w_state_next = StAbort;
                end
            end
            StRecv: begin
                o_busy   = 1'b1;
                o_WREADY = 1'b1;
                if (i_WVALID && (r_res_idx == w_n_last)) begin
                    w_state_next = StDone;
                end else if (w_timeout) begin
                    w_state_next = StAbort;
                end
            end
            StDone: begin
                o_busy       = 1'b1;
                o_done       = 1'b1;
                w_state_next = StIdle;
            end
            StAbort: begin
                o_busy       = 1'b1;
                w_state_next = StIdle;
            end
            default: begin
                w_state_next = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge n_Reset) begin
        if (!n_Reset) begin
            r_state    <= StIdle;
            r_n        <= '0;
            r_rd_idx   <= '0;
            r_beat_idx <= '0;
            r_res_idx  <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_start_ok) begin
                r_n        <= i_samp_number;
                r_rd_idx   <= '0;
                r_beat_idx <= '0;
                r_res_idx  <= '0;
            end else begin
                if (w_rd_issue) begin
                    r_rd_idx <= r_rd_idx + ADDR_W'(1);
                end
                if (w_beat) begin
                    r_beat_idx <= r_beat_idx + ADDR_W'(1);
                end
                if (o_dst_wr) begin
                    r_res_idx <= r_res_idx + ADDR_W'(1);
                end
            end
        end
    end

`ifdef DFT_HOST_TIMEOUT_EN
    localparam int unsigned WDOG_W = $clog2(TIMEOUT_CYC + 1);

    logic [WDOG_W-1:0] r_wdog;
    logic              w_active;
    logic              w_handshake;

    assign w_active    = (r_state == StSend) || (r_state == StRecv);
    assign w_handshake = w_beat || o_dst_wr;
    // r_wdog counts stalled cycles already elapsed; this one is the last allowed.
    assign w_timeout   = w_active && !w_handshake &&
                         (r_wdog == WDOG_W'(TIMEOUT_CYC - 1));
    assign o_error     = (r_state == StAbort);

    always_ff @(posedge clk or negedge n_Reset) begin
        if (!n_Reset) begin
            r_wdog <= '0;
        end else if (w_start_ok || w_handshake || !w_active) begin
            r_wdog <= '0;
        end else begin
            r_wdog <= r_wdog + WDOG_W'(1);
        end
    end
`else
    assign w_timeout = 1'b0;
    assign o_error   = 1'b0;
`endif

endmodule

// File: tb/tb_dft_host_link.sv
module tb_dft_host_link;

    localparam int unsigned ADDR_W  = 12;
    localparam int unsigned BURST_W = 4;
    localparam int unsigned TO_CYC  = 32;

    logic               clk = 1'b0;
    logic               n_Reset;
    logic               i_start;
    logic [ADDR_W-1:0]  i_samp_number;
    logic               o_busy, o_done, o_error;
    logic [ADDR_W-1:0]  o_src_addr;
    logic               o_src_rd;
    logic [31:0]        i_src_data;
    logic [ADDR_W-1:0]  o_dst_addr;
    logic               o_dst_wr;
    logic [31:0]        o_dst_data;
    logic [31:0]        o_RDATA;
    logic               o_RVALID;
    logic               i_RREADY;
    logic [BURST_W-1:0] i_RBURST;
    logic [31:0]        i_WDATA;
    logic               i_WVALID;
    logic               o_WREADY;
    logic [BURST_W-1:0] i_WBURST;

    always #5 clk = ~clk;

    dft_host_link #(
        .ADDR_W      (ADDR_W),
        .BURST_W     (BURST_W),
        .TIMEOUT_CYC (TO_CYC)
    ) dut (
        .clk           (clk),
        .n_Reset       (n_Reset),
        .i_start       (i_start),
        .i_samp_number (i_samp_number),
        .o_busy        (o_busy),
        .o_done        (o_done),
        .o_error       (o_error),
        .o_src_addr    (o_src_addr),
        .o_src_rd      (o_src_rd),
        .i_src_data    (i_src_data),
        .o_dst_addr    (o_dst_addr),
        .o_dst_wr      (o_dst_wr),
        .o_dst_data    (o_dst_data),
        .o_RDATA       (o_RDATA),
        .o_RVALID      (o_RVALID),
        .i_RREADY      (i_RREADY),
        .i_RBURST      (i_RBURST),
        .i_WDATA       (i_WDATA),
        .i_WVALID      (i_WVALID),
        .o_WREADY      (o_WREADY),
        .i_WBURST      (i_WBURST)
    );

    int tests_run    = 0;
    int tests_failed = 0;

    logic [31:0] src_mem [4096];
    logic [31:0] dst_mem [4096];
    logic [31:0] got_q [$];

    int cyc = 0;
    int cur_n;
    int first_beat_cyc, last_beat_cyc, first_wr_cyc, last_wr_cyc, done_cyc, err_cyc;
    int dst_cnt, done_cnt, err_cnt, stall_bad, send_wr;
    logic        prev_stall;
    logic [31:0] prev_data;

    // Clear per-test monitor state.
    task automatic clear_mon();
        got_q.delete();
        dst_cnt = 0; done_cnt = 0; err_cnt = 0; stall_bad = 0; send_wr = 0;
        first_beat_cyc = -1; last_beat_cyc = -1; first_wr_cyc = -1; last_wr_cyc = -1;
        done_cyc = -1; err_cyc = -1;
        prev_stall = 1'b0; prev_data = '0;
        for (int k = 0; k < 32; k++) dst_mem[k] = '0;
    endtask

    // Called at posedge+1 with inputs set; samples mid-cycle, advances one clock,
    // and models the synchronous-read source memory.
    task automatic tick();
        logic              rd_now;
        logic [ADDR_W-1:0] rd_addr;
        #1;
        rd_now  = o_src_rd;
        rd_addr = o_src_addr;
        if (prev_stall && (!o_RVALID || (o_RDATA !== prev_data))) stall_bad++;
        prev_stall = o_RVALID && !i_RREADY;
        prev_data  = o_RDATA;
        if (o_dst_wr) begin
            if (got_q.size() < cur_n) send_wr++;
            dst_mem[o_dst_addr] = o_dst_data;
            if (dst_cnt == 0) first_wr_cyc = cyc;
            dst_cnt++;
            last_wr_cyc = cyc;
        end
        if (o_RVALID && i_RREADY) begin
            if (got_q.size() == 0) first_beat_cyc = cyc;
            last_beat_cyc = cyc;
            got_q.push_back(o_RDATA);
        end
        if (o_done) begin done_cnt++; done_cyc = cyc; end
        if (o_error) begin err_cnt++; err_cyc = cyc; end
        @(posedge clk);
        #1;
        cyc++;
        if (rd_now) i_src_data = src_mem[rd_addr];
    endtask

    task automatic pulse_start(input int n);
        i_start       = 1'b1;
        i_samp_number = ADDR_W'(n);
        tick();
        i_start       = 1'b0;
    endtask

    task automatic test_reset();
        n_Reset = 1'b0;
        i_start = 1'b1; i_samp_number = 12'd5;
        i_src_data = 32'hDEAD_BEEF; i_RREADY = 1'b1; i_RBURST = 4'h3;
        i_WDATA = 32'h1234_5678; i_WVALID = 1'b1; i_WBURST = 4'h5;
        repeat (3) @(posedge clk);
        #2;
        tests_run++;
        if ({o_busy, o_done, o_error, o_src_rd, o_dst_wr, o_RVALID, o_WREADY} !== 7'b0) begin
            tests_failed++;
            $display("FAIL reset_flags: got %b want 0000000",
                     {o_busy, o_done, o_error, o_src_rd, o_dst_wr, o_RVALID, o_WREADY});
        end
        tests_run++;
        if (o_RDATA !== 32'h0) begin
            tests_failed++; $display("FAIL reset_rdata: got %h want 0", o_RDATA);
        end
        tests_run++;
        if (o_dst_data !== 32'h0) begin
            tests_failed++; $display("FAIL reset_dst_data: got %h want 0", o_dst_data);
        end
        tests_run++;
        if ({o_src_addr, o_dst_addr} !== 24'h0) begin
            tests_failed++;
            $display("FAIL reset_addr: got %h/%h want 0/0", o_src_addr, o_dst_addr);
        end
        i_start = 1'b0; i_WVALID = 1'b0; i_RREADY = 1'b0; i_src_data = '0;
        @(posedge clk);
        #1;
        n_Reset = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_basic();
        int t, guard, bad;
        for (int k = 0; k < 32; k++) src_mem[k] = 32'h1000_0000 + k;
        clear_mon();
        cur_n = 8; i_RREADY = 1'b1; i_WVALID = 1'b1; i_WDATA = 32'hB000_0000;
        t = cyc;
        pulse_start(8);
        tests_run++;
        if ({o_busy, o_src_rd, o_RVALID, o_src_addr} !== {3'b110, 12'd0}) begin
            tests_failed++;
            $display("FAIL basic_first_cycle: got busy=%b rd=%b rvalid=%b addr=%0d want 1 1 0 0",
                     o_busy, o_src_rd, o_RVALID, o_src_addr);
        end
        guard = 0;
        while (done_cnt == 0 && guard < 100) begin
            i_WDATA = 32'hB000_0000 + dst_cnt;
            tick();
            guard++;
        end
        tests_run++;
        if (o_busy !== 1'b0) begin
            tests_failed++; $display("FAIL basic_busy_low: got %b want 0", o_busy);
        end
        tests_run++;
        if (done_cnt !== 1) begin
            tests_failed++; $display("FAIL basic_done_count: got %0d want 1", done_cnt);
        end
        bad = 0;
        for (int k = 0; k < got_q.size(); k++) if (got_q[k] !== 32'h1000_0000 + k) bad++;
        tests_run++;
        if (got_q.size() !== 8 || bad !== 0) begin
            tests_failed++;
            $display("FAIL basic_rdata: got %0d words (%0d wrong) want 8 (0 wrong)",
                     got_q.size(), bad);
        end
        tests_run++;
        if (first_beat_cyc !== t + 2 || last_beat_cyc !== t + 9) begin
            tests_failed++;
            $display("FAIL basic_beat_timing: got %0d..%0d want %0d..%0d",
                     first_beat_cyc - t, last_beat_cyc - t, 2, 9);
        end
        bad = 0;
        for (int k = 0; k < 8; k++) if (dst_mem[k] !== 32'hB000_0000 + k) bad++;
        tests_run++;
        if (dst_cnt !== 8 || bad !== 0) begin
            tests_failed++;
            $display("FAIL basic_results: got %0d writes (%0d wrong) want 8 (0 wrong)",
                     dst_cnt, bad);
        end
        tests_run++;
        if (first_wr_cyc !== t + 10 || last_wr_cyc !== t + 17 || done_cyc !== t + 18) begin
            tests_failed++;
            $display("FAIL basic_recv_timing: got wr %0d..%0d done %0d want 10..17 done 18",
                     first_wr_cyc - t, last_wr_cyc - t, done_cyc - t);
        end
    endtask

    task automatic test_stall();
        int guard, bad;
        for (int k = 0; k < 32; k++) src_mem[k] = 32'h2000_0000 ^ (k * 32'h0101);
        clear_mon();
        cur_n = 16; i_RREADY = 1'b0; i_WVALID = 1'b1; i_WDATA = 32'hA0A0_0000;
        pulse_start(16);
        guard = 0;
        while (done_cnt == 0 && guard < 400) begin
            i_RREADY = 1'($urandom_range(0, 1));
            tick();
            guard++;
        end
        bad = 0;
        for (int k = 0; k < got_q.size(); k++)
            if (got_q[k] !== (32'h2000_0000 ^ (k * 32'h0101))) bad++;
        tests_run++;
        if (got_q.size() !== 16 || bad !== 0) begin
            tests_failed++;
            $display("FAIL stall_order: got %0d words (%0d wrong) want 16 (0 wrong)",
                     got_q.size(), bad);
        end
        tests_run++;
        if (stall_bad !== 0) begin
            tests_failed++; $display("FAIL stall_hold: got %0d unstable cycles want 0", stall_bad);
        end
        tests_run++;
        if (dst_cnt !== 16 || done_cnt !== 1) begin
            tests_failed++;
            $display("FAIL stall_recv: got %0d writes %0d done want 16 writes 1 done",
                     dst_cnt, done_cnt);
        end
    endtask

    task automatic test_wvalid_in_send();
        int guard, bad, wready_bad;
        for (int k = 0; k < 32; k++) src_mem[k] = 32'h3000_0000 + k;
        clear_mon();
        cur_n = 4; i_RREADY = 1'b0; i_WVALID = 1'b1;
        pulse_start(4);
        guard = 0; wready_bad = 0;
        while (done_cnt == 0 && guard < 100) begin
            i_RREADY = cyc[0];
            i_WVALID = ~cyc[0];
            i_WDATA  = 32'hC000_0000 + dst_cnt;
            if (got_q.size() < 4 && o_busy && o_WREADY) wready_bad++;
            tick();
            guard++;
        end
        i_WVALID = 1'b0;
        tests_run++;
        if (send_wr !== 0 || wready_bad !== 0) begin
            tests_failed++;
            $display("FAIL send_no_write: got %0d writes %0d wready in SEND want 0 0",
                     send_wr, wready_bad);
        end
        bad = 0;
        for (int k = 0; k < 4; k++) if (dst_mem[k] !== 32'hC000_0000 + k) bad++;
        tests_run++;
        if (dst_cnt !== 4 || bad !== 0 || done_cnt !== 1) begin
            tests_failed++;
            $display("FAIL send_recv_count: got %0d writes (%0d wrong) %0d done want 4 0 1",
                     dst_cnt, bad, done_cnt);
        end
    endtask

    task automatic test_ignored_start();
        int guard, bad;
        for (int k = 0; k < 32; k++) src_mem[k] = 32'h4000_0000 + k;
        clear_mon();
        cur_n = 4; i_RREADY = 1'b0; i_WVALID = 1'b0;
        pulse_start(0);
        tick();
        tests_run++;
        if (o_busy !== 1'b0 || o_src_rd !== 1'b0) begin
            tests_failed++;
            $display("FAIL zero_len_start: got busy=%b rd=%b want 0 0", o_busy, o_src_rd);
        end
        pulse_start(4);
        repeat (3) tick();
        pulse_start(9);
        tests_run++;
        if (o_busy !== 1'b1 || o_src_addr !== 12'd2 || o_src_rd !== 1'b0) begin
            tests_failed++;
            $display("FAIL busy_start: got busy=%b addr=%0d rd=%b want 1 2 0",
                     o_busy, o_src_addr, o_src_rd);
        end
        i_RREADY = 1'b1; i_WVALID = 1'b1; i_WDATA = 32'h0;
        guard = 0;
        while (done_cnt == 0 && guard < 100) begin
            tick();
            guard++;
        end
        bad = 0;
        for (int k = 0; k < got_q.size(); k++) if (got_q[k] !== 32'h4000_0000 + k) bad++;
        tests_run++;
        if (got_q.size() !== 4 || bad !== 0 || dst_cnt !== 4) begin
            tests_failed++;
            $display("FAIL busy_start_len: got %0d words (%0d wrong) %0d writes want 4 0 4",
                     got_q.size(), bad, dst_cnt);
        end
    endtask

    task automatic test_reset_mid();
        int guard, bad;
        for (int k = 0; k < 32; k++) src_mem[k] = 32'h5000_0000 + k * 7;
        clear_mon();
        cur_n = 10; i_RREADY = 1'b1; i_WVALID = 1'b0;
        pulse_start(10);
        guard = 0;
        while (got_q.size() < 5 && guard < 50) begin
            tick();
            guard++;
        end
        tests_run++;
        if (got_q.size() !== 5 || o_RVALID !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_mid_pre: got %0d words rvalid=%b want 5 1",
                     got_q.size(), o_RVALID);
        end
        #2;
        n_Reset = 1'b0;
        #1;
        tests_run++;
        if ({o_busy, o_done, o_error, o_src_rd, o_dst_wr, o_RVALID, o_WREADY} !== 7'b0 ||
            o_RDATA !== 32'h0 || o_src_addr !== 12'd0) begin
            tests_failed++;
            $display("FAIL reset_mid_async: got flags=%b rdata=%h addr=%0d want 0 0 0",
                     {o_busy, o_done, o_error, o_src_rd, o_dst_wr, o_RVALID, o_WREADY},
                     o_RDATA, o_src_addr);
        end
        @(posedge clk);
        @(posedge clk);
        #1;
        n_Reset = 1'b1;
        @(posedge clk);
        #1;
        clear_mon();
        i_WVALID = 1'b1; i_WDATA = 32'h0;
        pulse_start(10);
        guard = 0;
        while (done_cnt == 0 && guard < 100) begin
            tick();
            guard++;
        end
        bad = 0;
        for (int k = 0; k < got_q.size(); k++) if (got_q[k] !== 32'h5000_0000 + k * 7) bad++;
        tests_run++;
        if (got_q.size() !== 10 || bad !== 0 || dst_cnt !== 10 || done_cnt !== 1) begin
            tests_failed++;
            $display("FAIL reset_mid_restart: got %0d words (%0d wrong) %0d writes %0d done want 10 0 10 1",
                     got_q.size(), bad, dst_cnt, done_cnt);
        end
    endtask

`ifdef DFT_HOST_TIMEOUT_EN
    task automatic test_timeout();
        int t, guard;
        clear_mon();
        cur_n = 4; i_RREADY = 1'b0; i_WVALID = 1'b0;
        t = cyc;
        pulse_start(4);
        guard = 0;
        while (err_cnt == 0 && guard < 100) begin
            tick();
            guard++;
        end
        tests_run++;
        if (err_cyc !== t + 33) begin
            tests_failed++;
            $display("FAIL timeout_cycle: got %0d want %0d", err_cyc - t, 33);
        end
        tests_run++;
        if (o_busy !== 1'b0 || o_RVALID !== 1'b0 || done_cnt !== 0) begin
            tests_failed++;
            $display("FAIL timeout_idle: got busy=%b rvalid=%b done=%0d want 0 0 0",
                     o_busy, o_RVALID, done_cnt);
        end
        tick();
        tests_run++;
        if (err_cnt !== 1) begin
            tests_failed++; $display("FAIL timeout_pulse: got %0d want 1", err_cnt);
        end
    endtask
`endif

    initial begin
        #500000;
        $display("FAIL global_timeout: got no finish want finish");
        $fatal(1, "simulation time limit");
    end

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_wvalid_in_send();
        test_ignored_start();
        test_reset_mid();
`ifdef DFT_HOST_TIMEOUT_EN
        test_timeout();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
